// File: rtl/writeback_arbiter.sv
// Write-back arbiter: three functional units hand results into one-entry
// holding buffers; a round-robin arbiter drains one buffer per cycle into the
// single register-file write port and reports the retirement to the scoreboard.
module writeback_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned ZERO_REG   = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            fu_valid,
    output logic [2:0]            fu_ready,
    input  logic [ADDR_WIDTH-1:0] fu_dest_0,
    input  logic [ADDR_WIDTH-1:0] fu_dest_1,
    input  logic [ADDR_WIDTH-1:0] fu_dest_2,
    input  logic [DATA_WIDTH-1:0] fu_result_0,
    input  logic [DATA_WIDTH-1:0] fu_result_1,
    input  logic [DATA_WIDTH-1:0] fu_result_2,
    output logic                  wb_write_enable,
    output logic [ADDR_WIDTH-1:0] wb_write_addr,
    output logic [DATA_WIDTH-1:0] wb_write_value,
    output logic                  retire_valid,
    output logic [1:0]            retire_fu,
    output logic [ADDR_WIDTH-1:0] retire_dest,
    output logic [15:0]           conflict_cycles
);

    localparam int unsigned NumFu = 3;
    localparam logic [ADDR_WIDTH-1:0] ZeroAddr = ADDR_WIDTH'(ZERO_REG);
    localparam logic [1:0] RrResetLast = 2'd2;  // makes FU0 the first candidate

    // Holding buffers, one per functional unit
    logic [NumFu-1:0]      hold_valid_q;
    logic [ADDR_WIDTH-1:0] hold_dest_q  [NumFu];
    logic [DATA_WIDTH-1:0] hold_value_q [NumFu];

    // Round-robin pointer: index of the most recently granted unit
    logic [1:0] rr_last_q;

    // Registered write-back / retire outputs
    logic                  wb_we_q;
    logic [ADDR_WIDTH-1:0] wb_addr_q;
    logic [DATA_WIDTH-1:0] wb_value_q;
    logic                  retire_valid_q;
    logic [1:0]            retire_fu_q;
    logic [ADDR_WIDTH-1:0] retire_dest_q;
    logic [15:0]           conflict_q;

    // Unpacked views of the per-FU input buses
    logic [ADDR_WIDTH-1:0] dest_in  [NumFu];
    logic [DATA_WIDTH-1:0] value_in [NumFu];

    assign dest_in[0]  = fu_dest_0;
    assign dest_in[1]  = fu_dest_1;
    assign dest_in[2]  = fu_dest_2;
    assign value_in[0] = fu_result_0;
    assign value_in[1] = fu_result_1;
    assign value_in[2] = fu_result_2;

    logic             grant_any;
    logic [1:0]       grant_idx;
    logic [NumFu-1:0] grant;
    logic [NumFu-1:0] accept;
    logic             contested;

    // Round-robin search starting just after the last winner; depends on state only
    always_comb begin
        logic [1:0] cand;
        cand      = 2'd0;
        grant_any = 1'b0;
        grant_idx = 2'd0;
        for (int unsigned k = 1; k <= NumFu; k++) begin
            cand = 2'((32'(rr_last_q) + k) % NumFu);
            if (!grant_any && hold_valid_q[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        grant = grant_any ? (3'b001 << grant_idx) : 3'b000;
    end

    // A slot can take a new result when empty or when it drains this cycle
    assign fu_ready  = {NumFu{~reset}} & (~hold_valid_q | grant);
    assign accept    = fu_valid & fu_ready;
    assign contested = (hold_valid_q[0] & hold_valid_q[1]) |
                       (hold_valid_q[0] & hold_valid_q[2]) |
                       (hold_valid_q[1] & hold_valid_q[2]);

    // Holding buffer load / drain; a refill in the drain cycle keeps the slot full
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid_q <= '0;
        end else begin
            for (int i = 0; i < NumFu; i++) begin
                if (accept[i]) begin
                    hold_valid_q[i] <= 1'b1;
                    hold_dest_q[i]  <= dest_in[i];
                    hold_value_q[i] <= value_in[i];
                end else if (grant[i]) begin
                    hold_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Write-back and retire outputs; address/value/fu/dest hold when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_q      <= RrResetLast;
            wb_we_q        <= 1'b0;
            wb_addr_q      <= '0;
            wb_value_q     <= '0;
            retire_valid_q <= 1'b0;
            retire_fu_q    <= 2'd0;
            retire_dest_q  <= '0;
        end else if (grant_any) begin
            rr_last_q      <= grant_idx;
            wb_we_q        <= (hold_dest_q[grant_idx] != ZeroAddr);
            wb_addr_q      <= hold_dest_q[grant_idx];
            wb_value_q     <= hold_value_q[grant_idx];
            retire_valid_q <= 1'b1;
            retire_fu_q    <= grant_idx;
            retire_dest_q  <= hold_dest_q[grant_idx];
        end else begin
            wb_we_q        <= 1'b0;
            retire_valid_q <= 1'b0;
        end
    end

    // Saturating count of cycles with two or more results waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q <= '0;
        end else if (contested && (conflict_q != 16'hFFFF)) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign wb_write_enable = wb_we_q;
    assign wb_write_addr   = wb_addr_q;
    assign wb_write_value  = wb_value_q;
    assign retire_valid    = retire_valid_q;
    assign retire_fu       = retire_fu_q;
    assign retire_dest     = retire_dest_q;
    assign conflict_cycles = conflict_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: directed stimulus pushes expected
// retirements in hand-computed grant order; a negedge monitor pops and compares.
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  fu_valid;
    logic [2:0]  fu_ready;
    logic [2:0]  fu_dest_0, fu_dest_1, fu_dest_2;
    logic [15:0] fu_result_0, fu_result_1, fu_result_2;
    logic        wb_write_enable;
    logic [2:0]  wb_write_addr;
    logic [15:0] wb_write_value;
    logic        retire_valid;
    logic [1:0]  retire_fu;
    logic [2:0]  retire_dest;
    logic [15:0] conflict_cycles;

    writeback_arbiter #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(3),
        .ZERO_REG  (7)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fu_valid       (fu_valid),
        .fu_ready       (fu_ready),
        .fu_dest_0      (fu_dest_0),
        .fu_dest_1      (fu_dest_1),
        .fu_dest_2      (fu_dest_2),
        .fu_result_0    (fu_result_0),
        .fu_result_1    (fu_result_1),
        .fu_result_2    (fu_result_2),
        .wb_write_enable(wb_write_enable),
        .wb_write_addr  (wb_write_addr),
        .wb_write_value (wb_write_value),
        .retire_valid   (retire_valid),
        .retire_fu      (retire_fu),
        .retire_dest    (retire_dest),
        .conflict_cycles(conflict_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fu;
        logic [2:0]  dest;
        logic [15:0] value;
        logic        we;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   retired_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [1:0] fu, input logic [2:0] dest, input logic [15:0] val);
        exp_t e;
        e.fu    = fu;
        e.dest  = dest;
        e.value = val;
        e.we    = (dest != 3'd7);
        exp_q.push_back(e);
    endtask

    // Monitor: every presented retirement must match the head of the scoreboard
    always @(negedge clk) begin
        if (retire_valid === 1'b1) begin
            retired_n++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_retire: got fu=%0d dest=%0d, expected none (t=%0t)",
                         retire_fu, retire_dest, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("retire_fu", 32'(retire_fu), 32'(e.fu));
                check("retire_dest", 32'(retire_dest), 32'(e.dest));
                check("wb_addr", 32'(wb_write_addr), 32'(e.dest));
                check("wb_value", 32'(wb_write_value), 32'(e.value));
                check("wb_enable", 32'(wb_write_enable), 32'(e.we));
            end
        end else if (wb_write_enable === 1'b1) begin
            total++;
            bad++;
            $display("FAIL write_without_retire: got we=1 retire_valid=0, expected we=0 (t=%0t)",
                     $time);
        end
    end

    // Entry and exit alignment: one time unit after a rising edge
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        check("ready_in_reset", 32'(fu_ready), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send(input logic [2:0] mask,
                        input logic [2:0] d0, input logic [15:0] r0,
                        input logic [2:0] d1, input logic [15:0] r1,
                        input logic [2:0] d2, input logic [15:0] r2);
        fu_valid    = mask;
        fu_dest_0   = d0;
        fu_result_0 = r0;
        fu_dest_1   = d1;
        fu_result_1 = r1;
        fu_dest_2   = d2;
        fu_result_2 = r2;
        @(negedge clk);
        check("send_ready", 32'(fu_ready & mask), 32'(mask));
        @(posedge clk);
        #1;
        fu_valid = 3'b000;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         base;
        int         ia;
        int         ic;
        int         cyc;
        logic [2:0] acc;

        reset       = 1'b1;
        fu_valid    = 3'b000;
        fu_dest_0   = '0;
        fu_dest_1   = '0;
        fu_dest_2   = '0;
        fu_result_0 = '0;
        fu_result_1 = '0;
        fu_result_2 = '0;

        // Reset state, then idle
        do_reset();
        @(negedge clk);
        check("rst_addr", 32'(wb_write_addr), 32'h0);
        check("rst_value", 32'(wb_write_value), 32'h0);
        check("rst_retire_fu", 32'(retire_fu), 32'h0);
        check("rst_retire_dest", 32'(retire_dest), 32'h0);
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge clk);
            check("idle_we", 32'(wb_write_enable), 32'h0);
            check("idle_retire", 32'(retire_valid), 32'h0);
            check("idle_conflict", 32'(conflict_cycles), 32'h0);
            check("idle_ready", 32'(fu_ready), 32'h7);
        end
        @(posedge clk);
        #1;

        // Single FU1 result, with latency checks
        push(2'd1, 3'd3, 16'h1234);
        send(3'b010, 3'd0, 16'h0, 3'd3, 16'h1234, 3'd0, 16'h0);
        @(negedge clk);
        check("fu1_lat_c1", 32'(retire_valid), 32'h0);
        @(negedge clk);
        check("fu1_lat_c2", 32'(retire_valid), 32'h1);
        check("fu1_lat_c2_we", 32'(wb_write_enable), 32'h1);
        @(negedge clk);
        check("fu1_lat_c3", 32'(retire_valid), 32'h0);
        @(posedge clk);
        #1;
        wait_drain("fu1_drain");

        // All three at once after reset: FU0, FU1, FU2 in order
        do_reset();
        push(2'd0, 3'd1, 16'hAAAA);
        push(2'd1, 3'd2, 16'hBBBB);
        push(2'd2, 3'd4, 16'hCCCC);
        send(3'b111, 3'd1, 16'hAAAA, 3'd2, 16'hBBBB, 3'd4, 16'hCCCC);
        wait_drain("all3_drain");
        check("all3_conflict", 32'(conflict_cycles), 32'd2);

        // FU0 and FU2 streaming: grants alternate, loser's ready drops
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push(2'd0, 3'd1, 16'hA000 + 16'(i));
            push(2'd2, 3'd2, 16'hC000 + 16'(i));
        end
        base = retired_n;
        ia   = 0;
        ic   = 0;
        cyc  = 0;
        while ((ia < 6 || ic < 6) && cyc < 40) begin
            fu_valid    = {ic < 6, 1'b0, ia < 6};
            fu_dest_0   = 3'd1;
            fu_result_0 = 16'hA000 + 16'(ia);
            fu_dest_2   = 3'd2;
            fu_result_2 = 16'hC000 + 16'(ic);
            @(negedge clk);
            if (cyc >= 1 && cyc <= 10)
                check("stream_ready", 32'(fu_ready), (cyc % 2 == 1) ? 32'h3 : 32'h6);
            acc = fu_valid & fu_ready;
            @(posedge clk);
            #1;
            if (acc[0]) ia++;
            if (acc[2]) ic++;
            cyc++;
        end
        fu_valid = 3'b000;
        check("stream_accepted", 32'(ia + ic), 32'd12);
        wait_drain("stream_drain");
        check("stream_count", 32'(retired_n - base), 32'd12);
        check("stream_conflict", 32'(conflict_cycles), 32'd11);

        // Destination 7 retires without a register write
        do_reset();
        push(2'd2, 3'd7, 16'hFFFF);
        send(3'b100, 3'd0, 16'h0, 3'd0, 16'h0, 3'd7, 16'hFFFF);
        wait_drain("zero_reg_drain");

        // Reset mid-operation: held FU1 result is dropped, pointer restarts
        do_reset();
        push(2'd0, 3'd5, 16'h1111);
        send(3'b011, 3'd5, 16'h1111, 3'd6, 16'h2222, 3'd0, 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_ready_low", 32'(fu_ready), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midrst_no_retire", 32'(retire_valid), 32'h0);
            check("midrst_ready", 32'(fu_ready), 32'h7);
        end
        @(posedge clk);
        #1;
        push(2'd0, 3'd1, 16'h3333);
        push(2'd2, 3'd2, 16'h4444);
        send(3'b101, 3'd1, 16'h3333, 3'd0, 16'h0, 3'd2, 16'h4444);
        wait_drain("midrst_drain");

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
